// File: rtl/adpll.sv
// adpll: all-digital frequency-locked loop that multiplies REF_CLK by M*BASE/WIN.
//   REF_CLK  - sole clock, all state on its rising edge
//   RESET    - asynchronous active-low reset
//   M        - multiplication factor, 0 behaves as 1
//   LOCK     - high after LOCK_CNT consecutive in-tolerance windows
//   POLARITY - last correction direction: 1 = speed up, 0 = slow down or hold
//   OUT_CLK  - synthesized clock, registered NCO MSB
module adpll #(
    parameter int ACC_W    = 16,
    parameter int WIN      = 256,
    parameter int BASE     = 8,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4
) (
    input  logic       REF_CLK,
    input  logic       RESET,
    input  logic [2:0] M,
    output logic       LOCK,
    output logic       POLARITY,
    output logic       OUT_CLK
);
    localparam int WIN_W = $clog2(WIN);
    localparam int LR_W  = $clog2(LOCK_CNT + 1);
    localparam logic [ACC_W-1:0] STEP_INIT = {3'b000, 1'b1, {(ACC_W-4){1'b0}}};
    localparam logic [ACC_W-1:0] FCW_MIN   = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] FCW_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    logic [ACC_W-1:0] acc_q, acc_d, fcw_q, fcw_d, step_q, step_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [8:0]       edge_q, edge_d;
    logic [LR_W-1:0]  lr_q, lr_d, lr_inc;
    logic [2:0]       m_q, m_d, m_eff;
    logic             out_q, out_d, prev_q, lock_q, lock_d, pol_q, pol_d;
    logic             dir_q, dir_d, dir_v_q, dir_v_d;
    logic             edge_det, win_end, up, dn, in_tol, halve;
    logic [9:0]       cnt, tgt;
    logic [ACC_W:0]   fcw_adj;
    logic [ACC_W-1:0] fcw_new, step_half;
    assign m_eff     = (M == 3'd0) ? 3'd1 : M;
    assign tgt       = 10'(m_q) * 10'(BASE);
    assign edge_det  = out_q & ~prev_q;
    assign win_end   = win_q == WIN_W'(WIN - 1);
    // An edge in the terminal cycle still belongs to the closing window.
    assign cnt       = {1'b0, edge_q} + 10'(edge_det);
    assign up        = cnt < tgt;
    assign dn        = cnt > tgt;
    assign in_tol    = (cnt + 10'(TOL) >= tgt) && (cnt <= tgt + 10'(TOL));
    // Binary search: halve the step only on a reversal of a real correction.
    assign halve     = (up | dn) && dir_v_q && (up != dir_q);
    assign step_half = (step_q[ACC_W-1:1] == '0) ? FCW_MIN : {1'b0, step_q[ACC_W-1:1]};
    // One extra bit so an underflow shows up as a set MSB before clamping.
    assign fcw_adj   = up ? {1'b0, fcw_q} + {1'b0, step_q}
                     : dn ? {1'b0, fcw_q} - {1'b0, step_q}
                     : {1'b0, fcw_q};
    assign fcw_new   = (fcw_adj[ACC_W] || fcw_adj == '0) ? FCW_MIN
                     : (fcw_adj[ACC_W-1:0] > FCW_MAX) ? FCW_MAX
                     : fcw_adj[ACC_W-1:0];
    assign lr_inc    = (lr_q == LR_W'(LOCK_CNT)) ? lr_q : lr_q + 1'b1;
    always_comb begin
        acc_d   = acc_q + fcw_q;
        out_d   = acc_q[ACC_W-1];
        m_d     = m_q;
        lock_d  = lock_q;
        pol_d   = pol_q;
        fcw_d   = fcw_q;
        step_d  = step_q;
        dir_d   = dir_q;
        dir_v_d = dir_v_q;
        lr_d    = lr_q;
        win_d   = win_q + 1'b1;
        edge_d  = edge_q + 9'(edge_det);
        // A new multiplier restarts the search from the current frequency.
        if (m_eff != m_q) begin
            m_d    = m_eff;
            lock_d = 1'b0;
            lr_d   = '0;
            step_d = STEP_INIT;
            win_d  = '0;
            edge_d = '0;
        end else if (win_end) begin
            pol_d   = up;
            fcw_d   = fcw_new;
            step_d  = halve ? step_half : step_q;
            dir_d   = (up | dn) ? up : dir_q;
            dir_v_d = dir_v_q | up | dn;
            win_d   = '0;
            edge_d  = '0;
            lr_d    = in_tol ? lr_inc : '0;
            lock_d  = in_tol && (lr_inc == LR_W'(LOCK_CNT));
        end
    end
    always_ff @(posedge REF_CLK or negedge RESET) begin
        if (!RESET) begin
            acc_q   <= '0;
            out_q   <= 1'b0;
            prev_q  <= 1'b0;
            m_q     <= m_eff;
            lock_q  <= 1'b0;
            pol_q   <= 1'b0;
            fcw_q   <= STEP_INIT;
            step_q  <= STEP_INIT;
            dir_q   <= 1'b0;
            dir_v_q <= 1'b0;
            lr_q    <= '0;
            win_q   <= '0;
            edge_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            out_q   <= out_d;
            prev_q  <= out_q;
            m_q     <= m_d;
            lock_q  <= lock_d;
            pol_q   <= pol_d;
            fcw_q   <= fcw_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            dir_v_q <= dir_v_d;
            lr_q    <= lr_d;
            win_q   <= win_d;
            edge_q  <= edge_d;
        end
    end
    assign LOCK     = lock_q;
    assign POLARITY = pol_q;
    assign OUT_CLK  = out_q;
endmodule

// File: tb/tb_adpll.sv
// tb_adpll: directed self-checking bench for adpll.
module tb_adpll;
    logic       REF_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [2:0] M = 3'd1;
    logic       LOCK, POLARITY, OUT_CLK;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] m;
        int         t;
    } vec_t;
    vec_t tbl [4];

    adpll dut (
        .REF_CLK (REF_CLK),
        .RESET   (RESET),
        .M       (M),
        .LOCK    (LOCK),
        .POLARITY(POLARITY),
        .OUT_CLK (OUT_CLK)
    );

    always #5 REF_CLK = ~REF_CLK;

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_lock(input string name, output int cyc);
        cyc = 0;
        while (!LOCK && cyc < 40 * 256) begin
            @(negedge REF_CLK);
            cyc++;
        end
        chk(name, int'(LOCK), 1, 1);
    endtask

    task automatic count_edges(output int n);
        logic prev;
        n = 0;
        prev = OUT_CLK;
        repeat (256) begin
            @(negedge REF_CLK);
            if (OUT_CLK && !prev) n++;
            prev = OUT_CLK;
        end
    endtask

    // Release at a falling edge: with fcw=4096 the first rise is on rising edge 9, then every 16.
    task automatic release_rises(input string name);
        int r1 = 0;
        int r2 = 0;
        logic prev = 1'b0;
        RESET = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge REF_CLK);
            if (OUT_CLK && !prev) begin
                if (r1 == 0) r1 = k;
                else if (r2 == 0) r2 = k;
            end
            prev = OUT_CLK;
        end
        chk({name, "_first_rise"}, r1, 9, 9);
        chk({name, "_period"}, r2 - r1, 16, 16);
    endtask

    initial begin
        int c, e, r1, r2, k;
        logic prev;
        tbl[0] = '{3'd7, 56};
        tbl[1] = '{3'd0, 8};
        tbl[2] = '{3'd3, 24};
        tbl[3] = '{3'd1, 8};
        #1 RESET = 1'b0;
        repeat (7) begin
            @(negedge REF_CLK);
            chk("reset_outputs", int'({LOCK, POLARITY, OUT_CLK}), 0, 0);
        end
        release_rises("release");
        // Window 1: 16 edges -> slow down; window 2: fcw clamped to 1, 0 edges -> speed up;
        // window 3: fcw 4097, 16 edges -> slow down to 2049; windows 4..7 hold 8 edges -> LOCK.
        for (int n = 31; n <= 1792; n++) begin
            @(negedge REF_CLK);
            if (n == 256 || n == 511 || n == 768) chk($sformatf("pol_low_n%0d", n), int'(POLARITY), 0, 0);
            if (n == 512 || n == 767) chk($sformatf("pol_high_n%0d", n), int'(POLARITY), 1, 1);
            if (n == 1791) chk("lock_before_4th_window", int'(LOCK), 0, 0);
            if (n == 1792) chk("lock_after_4th_window", int'(LOCK), 1, 1);
        end
        r1 = 0;
        r2 = 0;
        prev = OUT_CLK;
        for (int n = 0; n < 80 && r2 == 0; n++) begin
            @(negedge REF_CLK);
            if (OUT_CLK && !prev) begin
                if (r1 == 0) r1 = n;
                else r2 = n;
            end
            prev = OUT_CLK;
        end
        chk("m1_locked_period", r2 - r1, 31, 33);
        foreach (tbl[i]) begin
            M = tbl[i].m;
            @(negedge REF_CLK);
            chk($sformatf("m%0d_lock_drop", tbl[i].m), int'(LOCK), 0, 0);
            wait_lock($sformatf("m%0d_relock", tbl[i].m), c);
            count_edges(e);
            chk($sformatf("m%0d_edges_per_window", tbl[i].m), e, tbl[i].t - 1, tbl[i].t + 1);
        end
        M = 3'd2;
        @(negedge REF_CLK);
        M = 3'd1;
        @(negedge REF_CLK);
        chk("disturb_lock_drop", int'(LOCK), 0, 0);
        wait_lock("disturb_relock", c);
        chk("disturb_relock_delay", c, 1000, 40 * 256);
        chk("lock_before_reset", int'(LOCK), 1, 1);
        k = 0;
        while (!OUT_CLK && k < 64) begin
            @(negedge REF_CLK);
            k++;
        end
        chk("outclk_high_before_reset", int'(OUT_CLK), 1, 1);
        #1 RESET = 1'b0;
        #1;
        chk("async_lock_clear", int'(LOCK), 0, 0);
        chk("async_outclk_clear", int'(OUT_CLK), 0, 0);
        repeat (3) @(negedge REF_CLK);
        release_rises("rerelease");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
